muldiv_ctrl: RTL and testbench

Iterative multiply/divide sequencer that owns the HI/LO write path of the pipelined datapath. It accepts a mult/multu/div/divu issued from the execute stage and runs a shift-add multiply or restoring divide over many cycles. It then drives the HI/LO register enables and values, and raises a stall request so the hazard unit holds decode-stage readers of HI/LO until the result is committed.

---
 rtl/muldiv_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative multiply/divide sequencer that owns the HI/LO write path.
// It runs a shift-add multiply or a restoring divide, one step per cycle, and
// pulses the HI/LO write enables with the fixed-up result.
// Optional build macro: MULDIV_EARLY_EXIT_EN lets a multiply stop as soon as
// the remaining multiplier bits are all zero.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        startE,
  input  logic [1:0]  opE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic        hiloreadD,
  output logic        busy,
  output logic        stallhilo,
  output logic        hien,
  output logic        loen,
  output logic [31:0] hiout,
  output logic [31:0] loout
);

  typedef enum logic [1:0] {IDLE, RUN, FIXUP, WRITE} state_t;

  state_t      r_state;
  logic [1:0]  r_op;
  logic        r_signA;
  logic        r_signB;
  logic        r_divZero;
  logic [31:0] r_rawA;
  logic [31:0] r_acc;
  logic [31:0] r_lo;
  logic [31:0] r_b;
  logic [5:0]  r_count;
  logic        r_busy;
  logic        r_hien;
  logic [31:0] r_hiout;
  logic [31:0] r_loout;
`ifdef MULDIV_EARLY_EXIT_EN
  logic [31:0] r_mrem;
  logic [31:0] w_mremNext;
`endif

  logic        w_isDiv;
  logic [31:0] w_absA;
  logic [31:0] w_absB;
  logic [31:0] w_addend;
  logic [32:0] w_sum;
  logic [63:0] w_mulNext;
  logic [32:0] w_shift;
  logic [32:0] w_trial;
  logic        w_divOk;
  logic [31:0] w_remNext;
  logic [31:0] w_quoNext;
  logic        w_lastStep;
  logic [63:0] w_prodAligned;
  logic [63:0] w_prodFinal;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_isDiv = r_op[1];

  // Magnitudes are taken only for the signed opcodes (opE[0] == 0).
  assign w_absA = (~opE[0] & srcaE[31]) ? (32'd0 - srcaE) : srcaE;
  assign w_absB = (~opE[0] & srcbE[31]) ? (32'd0 - srcbE) : srcbE;

  // One shift-add multiply step on {acc, multiplier}; the carry enters the top.
  assign w_addend  = r_lo[0] ? r_b : 32'd0;
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_addend};
  assign w_mulNext = {w_sum, r_lo[31:1]};

  // One restoring divide step; the remainder is always below the divisor, so a
  // 33-bit trial difference is enough to decide the quotient bit from its sign.
  assign w_shift   = {r_acc, r_lo[31]};
  assign w_trial   = w_shift - {1'b0, r_b};
  assign w_divOk   = ~w_trial[32];
  assign w_remNext = w_divOk ? w_trial[31:0] : w_shift[31:0];
  assign w_quoNext = {r_lo[30:0], w_divOk};

`ifdef MULDIV_EARLY_EXIT_EN
  // A multiply finishes once no multiplier bits remain; divide always runs 32 steps.
  assign w_mremNext = r_mrem >> 1;
  assign w_lastStep = w_isDiv ? (r_count == 6'd31) : (w_mremNext == 32'd0);
`else
  assign w_lastStep = (r_count == 6'd31);
`endif

  // After an early exit the product sits high in {acc, lo}; shift it down by
  // the steps that were skipped (zero shift after a full 32-step run).
  assign w_prodAligned = {r_acc, r_lo} >> (6'd32 - r_count);
  assign w_prodFinal   = ((r_op == 2'b00) && (r_signA ^ r_signB)) ? (64'd0 - w_prodAligned) : w_prodAligned;
  assign w_quo         = ((r_op == 2'b10) && (r_signA ^ r_signB)) ? (32'd0 - r_lo) : r_lo;
  assign w_rem         = ((r_op == 2'b10) && r_signA) ? (32'd0 - r_acc) : r_acc;

  assign busy      = r_busy;
  assign hien      = r_hien;
  assign loen      = r_hien;
  assign hiout     = r_hiout;
  assign loout     = r_loout;
  assign stallhilo = hiloreadD & (startE | r_busy);

  // Sequencer: latch operands, iterate, fix up signs, then pulse the HI/LO write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_op      <= 2'b00;
      r_signA   <= 1'b0;
      r_signB   <= 1'b0;
      r_divZero <= 1'b0;
      r_rawA    <= 32'd0;
      r_acc     <= 32'd0;
      r_lo      <= 32'd0;
      r_b       <= 32'd0;
      r_count   <= 6'd0;
      r_busy    <= 1'b0;
      r_hien    <= 1'b0;
      r_hiout   <= 32'd0;
      r_loout   <= 32'd0;
`ifdef MULDIV_EARLY_EXIT_EN
      r_mrem    <= 32'd0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_hien <= 1'b0;
          if (startE) begin
            r_op      <= opE;
            r_signA   <= ~opE[0] & srcaE[31];
            r_signB   <= ~opE[0] & srcbE[31];
            r_divZero <= opE[1] & (srcbE == 32'd0);
            r_rawA    <= srcaE;
            r_acc     <= 32'd0;
            r_count   <= 6'd0;
            r_b       <= opE[1] ? w_absB : w_absA;
            r_lo      <= opE[1] ? w_absA : w_absB;
            r_busy    <= 1'b1;
            r_state   <= RUN;
`ifdef MULDIV_EARLY_EXIT_EN
            r_mrem    <= w_absB;
`endif
          end
        end
        RUN: begin
          if (w_isDiv) begin
            r_acc <= w_remNext;
            r_lo  <= w_quoNext;
          end else begin
            r_acc <= w_mulNext[63:32];
            r_lo  <= w_mulNext[31:0];
          end
`ifdef MULDIV_EARLY_EXIT_EN
          r_mrem <= w_mremNext;
`endif
          r_count <= r_count + 6'd1;
          if (w_lastStep) begin
            r_state <= FIXUP;
          end
        end
        FIXUP: begin
          if (r_divZero) begin
            r_hiout <= r_rawA;
            r_loout <= 32'hFFFF_FFFF;
          end else if (w_isDiv) begin
            r_hiout <= w_rem;
            r_loout <= w_quo;
          end else begin
            r_hiout <= w_prodFinal[63:32];
            r_loout <= w_prodFinal[31:0];
          end
          r_hien  <= 1'b1;
          r_state <= WRITE;
        end
        WRITE: begin
          r_hien  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed bench for muldiv_ctrl with a result scoreboard.
// Honours MULDIV_EARLY_EXIT_EN when computing expected busy lengths.
module tb_muldiv_ctrl;

  logic        clk;
  logic        reset;
  logic        startE;
  logic [1:0]  opE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        hiloreadD;
  logic        busy;
  logic        stallhilo;
  logic        hien;
  logic        loen;
  logic [31:0] hiout;
  logic [31:0] loout;

  int checks = 0;
  int errors = 0;
  logic [63:0] expQ[$];

  muldiv_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .startE    (startE),
    .opE       (opE),
    .srcaE     (srcaE),
    .srcbE     (srcbE),
    .hiloreadD (hiloreadD),
    .busy      (busy),
    .stallhilo (stallhilo),
    .hien      (hien),
    .loen      (loen),
    .hiout     (hiout),
    .loout     (loout)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point with an immediate assertion
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference result as {hi, lo}
  function automatic logic [63:0] modelResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] pa;
    logic signed [63:0] pb;
    int sa;
    int sb;
    int q;
    int r;
    if (op[1] && (b == 32'd0)) return {a, 32'hFFFF_FFFF};
    case (op)
      2'b00: begin
        pa = {{32{a[31]}}, a};
        pb = {{32{b[31]}}, b};
        return pa * pb;
      end
      2'b01: return {32'd0, a} * {32'd0, b};
      2'b10: begin
        sa = a;
        sb = b;
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: return {a % b, a / b};
    endcase
  endfunction

  // Expected busy length in cycles
  function automatic int expBusy(input logic [1:0] op, input logic [31:0] b);
`ifdef MULDIV_EARLY_EXIT_EN
    logic [31:0] m;
    int steps;
    if (!op[1]) begin
      m = ((op == 2'b00) && b[31]) ? (32'd0 - b) : b;
      steps = 0;
      do begin
        m = m >> 1;
        steps++;
      end while (m != 32'd0);
      return steps + 2;
    end
`endif
    if (op[1] === 1'b1 || op[1] === 1'b0) return 34;
    return 34;
  endfunction

  // Issue one operation, push its expected result, and follow it to completion
  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic hold);
    int busyCycles;
    int hienCount;
    int hienIdx;
    int stallBad;
    int eb;
    logic [63:0] exp;
    eb = expBusy(op, b);
    @(negedge clk);
    startE = 1'b1;
    opE = op;
    srcaE = a;
    srcbE = b;
    hiloreadD = hold;
    expQ.push_back(modelResult(op, a, b));
    #1;
    if (hold) checkOutput({tag, " stall_start"}, {63'd0, stallhilo}, 64'd1);
    @(negedge clk);
    startE = 1'b0;
    srcaE = 32'hDEAD_BEEF;
    srcbE = 32'h0BAD_F00D;
    busyCycles = 0;
    hienCount = 0;
    hienIdx = -1;
    stallBad = 0;
    for (int c = 0; c < 100 && busy === 1'b1; c++) begin
      if (stallhilo !== hold) stallBad++;
      if (hien === 1'b1) begin
        hienCount++;
        hienIdx = c;
        checkOutput({tag, " loen"}, {63'd0, loen}, 64'd1);
        if (expQ.size() == 0) begin
          checkOutput({tag, " scoreboard_empty"}, 64'd0, 64'd1);
        end else begin
          exp = expQ.pop_front();
          checkOutput({tag, " hi"}, {32'd0, hiout}, {32'd0, exp[63:32]});
          checkOutput({tag, " lo"}, {32'd0, loout}, {32'd0, exp[31:0]});
        end
      end
      busyCycles++;
      @(negedge clk);
    end
    checkOutput({tag, " busy_cycles"}, 64'(busyCycles), 64'(eb));
    checkOutput({tag, " hien_count"}, 64'(hienCount), 64'd1);
    checkOutput({tag, " hien_cycle"}, 64'(hienIdx), 64'(eb - 1));
    checkOutput({tag, " stall_during"}, 64'(stallBad), 64'd0);
    checkOutput({tag, " idle_hien"}, {62'd0, hien, loen}, 64'd0);
    checkOutput({tag, " idle_stall"}, {63'd0, stallhilo}, 64'd0);
    hiloreadD = 1'b0;
  endtask

  initial begin
    int hienSeen;
    reset = 1'b1;
    startE = 1'b0;
    opE = 2'b00;
    srcaE = 32'd0;
    srcbE = 32'd0;
    hiloreadD = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", {63'd0, busy}, 64'd0);
    checkOutput("reset stall", {63'd0, stallhilo}, 64'd0);
    checkOutput("reset en", {62'd0, hien, loen}, 64'd0);
    checkOutput("reset hilo", {hiout, loout}, 64'd0);
    reset = 1'b0;

    applyStimulus("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    applyStimulus("mult_neg", 2'b00, 32'hFFFF_FFFA, 32'd7, 1'b0);
    applyStimulus("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    applyStimulus("divu_zero", 2'b11, 32'd100, 32'd0, 1'b0);
    applyStimulus("div_zero", 2'b10, 32'hFFFF_FFFB, 32'd0, 1'b1);
    applyStimulus("mult_negneg", 2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b0);
    applyStimulus("divu_plain", 2'b11, 32'd1000, 32'd7, 1'b0);
    applyStimulus("div_negdiv", 2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);

    // Constant spot checks against the worked examples
    checkOutput("model multu_max", modelResult(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    checkOutput("model div_neg", modelResult(2'b10, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);

    // Reset in the tenth RUN cycle of a divide discards the result
    @(negedge clk);
    startE = 1'b1;
    opE = 2'b10;
    srcaE = 32'd12345;
    srcbE = 32'd17;
    @(negedge clk);
    startE = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midreset busy", {63'd0, busy}, 64'd0);
    checkOutput("midreset en", {62'd0, hien, loen}, 64'd0);
    hienSeen = 0;
    for (int c = 0; c < 40; c++) begin
      if (hien !== 1'b0 || loen !== 1'b0) hienSeen++;
      @(negedge clk);
    end
    checkOutput("midreset no_write", 64'(hienSeen), 64'd0);

    applyStimulus("multu_3x4", 2'b01, 32'd3, 32'd4, 1'b0);
    applyStimulus("multu_3x5", 2'b01, 32'd3, 32'd5, 1'b0);
    applyStimulus("multu_9x0", 2'b01, 32'd9, 32'd0, 1'b0);
    applyStimulus("mult_neg_small", 2'b00, 32'd5, 32'hFFFF_FFFD, 1'b0);

    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
